// File: rtl/conv_pe_pkg.sv
// Shared types and default widths for the 1-D convolution PE sequencer.
// Types: state_e (sequencer FSM), hs_phase_e (per-channel handshake phase).
package conv_pe_pkg;

    localparam int CONV_WIDTH   = 8;
    localparam int CONV_DEPTH_F = 3;
    localparam int CONV_PWIDTH  = 2 * CONV_WIDTH;
    localparam int CONV_PSUM_W  = CONV_PWIDTH + $clog2(CONV_DEPTH_F);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_MUL_SEND,
        S_MUL_RECV,
        S_ACC,
        S_PSUM_SEND,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_REL
    } hs_phase_e;

endpackage

// File: rtl/conv1d_pe_sequencer_hs_port.sv
// One 4-phase bundled-data channel engine (SEND=1: we drive req, SEND=0: we drive ack).
// Optional CONV_PE_SYNC_EN: incoming req/ack passes a 2-flop synchronizer.
module hs_port
    import conv_pe_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SEND = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_go,
    input  logic         i_peer,
    input  logic [W-1:0] i_data,
    output logic         o_hs,
    output logic [W-1:0] o_data,
    output logic         o_done
);

    logic      w_peer;
    hs_phase_e r_phase;
    hs_phase_e w_phase_nxt;
    logic      r_pend;
    logic      w_launch;
    logic      w_done;
    logic [W-1:0] r_data;

`ifdef CONV_PE_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_peer};
    end
    assign w_peer = r_sync[1];
`else
    assign w_peer = i_peer;
`endif

    // A launch waits for the peer line to be low, so a level left high is never taken as a new edge.
    always_comb begin
        w_phase_nxt = r_phase;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        case (r_phase)
            HS_IDLE: if ((i_go || r_pend) && !w_peer) begin
                w_phase_nxt = HS_REQ;
                w_launch    = 1'b1;
            end
            HS_REQ:  if (w_peer) w_phase_nxt = HS_REL;
            HS_REL:  if (!w_peer) begin
                w_phase_nxt = HS_IDLE;
                w_done      = 1'b1;
            end
            default: w_phase_nxt = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= HS_IDLE;
            r_pend  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_pend  <= (r_pend | i_go) & ~w_launch;
            if (SEND) begin
                if (w_launch) r_data <= i_data;
            end else if (r_phase == HS_REQ && w_peer) begin
                r_data <= i_data;
            end
        end
    end

    assign o_hs   = SEND ? (r_phase == HS_REQ) : (r_phase == HS_REL);
    assign o_data = r_data;
    assign o_done = w_done;

endmodule

// File: rtl/conv1d_pe_sequencer.sv
// Sequencer for one 1-D convolution PE: fetch operands, multiply, accumulate, emit psums.
// Build option CONV_PE_SYNC_EN (see hs_port) adds input synchronizers on every channel.
module conv1d_pe_sequencer
    import conv_pe_pkg::*;
#(
    parameter int WIDTH   = CONV_WIDTH,
    parameter int DEPTH_I = 5,
    parameter int ADDR_I  = 3,
    parameter int DEPTH_F = CONV_DEPTH_F,
    parameter int ADDR_F  = 2,
    parameter int PWIDTH  = 2 * WIDTH,
    parameter int PSUM_W  = PWIDTH + $clog2(DEPTH_F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              if_raddr_req,
    input  logic              if_raddr_ack,
    output logic [ADDR_I-1:0] if_raddr_data,
    input  logic              if_rdata_req,
    output logic              if_rdata_ack,
    input  logic [WIDTH-1:0]  if_rdata_data,
    output logic              f_raddr_req,
    input  logic              f_raddr_ack,
    output logic [ADDR_F-1:0] f_raddr_data,
    input  logic              f_rdata_req,
    output logic              f_rdata_ack,
    input  logic [WIDTH-1:0]  f_rdata_data,
    output logic              mul_a_req,
    input  logic              mul_a_ack,
    output logic [WIDTH-1:0]  mul_a_data,
    output logic              mul_b_req,
    input  logic              mul_b_ack,
    output logic [WIDTH-1:0]  mul_b_data,
    input  logic              mul_p_req,
    output logic              mul_p_ack,
    input  logic [PWIDTH-1:0] mul_p_data,
    output logic              psum_req,
    input  logic              psum_ack,
    output logic [PSUM_W-1:0] psum_data
);

    localparam logic [ADDR_F-1:0] F_LAST = ADDR_F'(DEPTH_F - 1);
    localparam logic [ADDR_I-1:0] O_LAST = ADDR_I'(DEPTH_I - DEPTH_F);

    state_e r_state, w_next;
    logic   r_entry;
    logic   r_j0, r_j1;
    logic   w_d0, w_d1, w_h0, w_h1, w_join;
    logic [ADDR_I-1:0] r_o;
    logic [ADDR_F-1:0] r_f;
    logic [PSUM_W-1:0] r_psum;
    logic [ADDR_I-1:0] w_if_addr;
    logic [WIDTH-1:0]  w_if_val, w_f_val;
    logic [PWIDTH-1:0] w_prod;
    logic w_go_raddr, w_go_rdata, w_go_mul_send, w_go_mul_recv, w_go_psum;
    logic w_ira_done, w_fra_done, w_ird_done, w_frd_done;
    logic w_ma_done, w_mb_done, w_mp_done, w_ps_done;

    assign w_if_addr     = r_o + ADDR_I'(r_f);
    assign w_go_raddr    = r_entry && (r_state == S_RADDR);
    assign w_go_rdata    = r_entry && (r_state == S_RDATA);
    assign w_go_mul_send = r_entry && (r_state == S_MUL_SEND);
    assign w_go_mul_recv = r_entry && (r_state == S_MUL_RECV);
    assign w_go_psum     = r_entry && (r_state == S_PSUM_SEND);

    hs_port #(.W(ADDR_I), .SEND(1'b1)) u_if_raddr (
        .clk(clk), .rst(rst), .i_go(w_go_raddr), .i_peer(if_raddr_ack), .i_data(w_if_addr),
        .o_hs(if_raddr_req), .o_data(if_raddr_data), .o_done(w_ira_done));
    hs_port #(.W(ADDR_F), .SEND(1'b1)) u_f_raddr (
        .clk(clk), .rst(rst), .i_go(w_go_raddr), .i_peer(f_raddr_ack), .i_data(r_f),
        .o_hs(f_raddr_req), .o_data(f_raddr_data), .o_done(w_fra_done));
    hs_port #(.W(WIDTH), .SEND(1'b0)) u_if_rdata (
        .clk(clk), .rst(rst), .i_go(w_go_rdata), .i_peer(if_rdata_req), .i_data(if_rdata_data),
        .o_hs(if_rdata_ack), .o_data(w_if_val), .o_done(w_ird_done));
    hs_port #(.W(WIDTH), .SEND(1'b0)) u_f_rdata (
        .clk(clk), .rst(rst), .i_go(w_go_rdata), .i_peer(f_rdata_req), .i_data(f_rdata_data),
        .o_hs(f_rdata_ack), .o_data(w_f_val), .o_done(w_frd_done));
    hs_port #(.W(WIDTH), .SEND(1'b1)) u_mul_a (
        .clk(clk), .rst(rst), .i_go(w_go_mul_send), .i_peer(mul_a_ack), .i_data(w_if_val),
        .o_hs(mul_a_req), .o_data(mul_a_data), .o_done(w_ma_done));
    hs_port #(.W(WIDTH), .SEND(1'b1)) u_mul_b (
        .clk(clk), .rst(rst), .i_go(w_go_mul_send), .i_peer(mul_b_ack), .i_data(w_f_val),
        .o_hs(mul_b_req), .o_data(mul_b_data), .o_done(w_mb_done));
    hs_port #(.W(PWIDTH), .SEND(1'b0)) u_mul_p (
        .clk(clk), .rst(rst), .i_go(w_go_mul_recv), .i_peer(mul_p_req), .i_data(mul_p_data),
        .o_hs(mul_p_ack), .o_data(w_prod), .o_done(w_mp_done));
    hs_port #(.W(PSUM_W), .SEND(1'b1)) u_psum (
        .clk(clk), .rst(rst), .i_go(w_go_psum), .i_peer(psum_ack), .i_data(r_psum),
        .o_hs(psum_req), .o_data(psum_data), .o_done(w_ps_done));

    // Paired states leave only once both halves have reported done, in any order.
    always_comb begin
        w_d0 = 1'b0;
        w_d1 = 1'b0;
        case (r_state)
            S_RADDR:    begin w_d0 = w_ira_done; w_d1 = w_fra_done; end
            S_RDATA:    begin w_d0 = w_ird_done; w_d1 = w_frd_done; end
            S_MUL_SEND: begin w_d0 = w_ma_done;  w_d1 = w_mb_done;  end
            default:    ;
        endcase
        w_h0   = r_j0 | w_d0;
        w_h1   = r_j1 | w_d1;
        w_join = w_h0 & w_h1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_RADDR;
            S_RADDR:     if (w_join) w_next = S_RDATA;
            S_RDATA:     if (w_join) w_next = S_MUL_SEND;
            S_MUL_SEND:  if (w_join) w_next = S_MUL_RECV;
            S_MUL_RECV:  if (w_mp_done) w_next = S_ACC;
            S_ACC:       w_next = (r_f < F_LAST) ? S_RADDR : S_PSUM_SEND;
            S_PSUM_SEND: if (w_ps_done) w_next = (r_o < O_LAST) ? S_RADDR : S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_entry <= 1'b0;
            r_j0    <= 1'b0;
            r_j1    <= 1'b0;
            r_o     <= '0;
            r_f     <= '0;
            r_psum  <= '0;
        end else begin
            r_state <= w_next;
            r_entry <= (w_next != r_state);
            if (w_next != r_state) begin
                r_j0 <= 1'b0;
                r_j1 <= 1'b0;
            end else begin
                r_j0 <= w_h0;
                r_j1 <= w_h1;
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_o    <= '0;
                    r_f    <= '0;
                    r_psum <= '0;
                end
                S_ACC: begin
                    r_psum <= r_psum + PSUM_W'(w_prod);
                    if (r_f < F_LAST) r_f <= r_f + 1'b1;
                end
                S_PSUM_SEND: if (w_ps_done) begin
                    r_f    <= '0;
                    r_psum <= '0;
                    if (r_o < O_LAST) r_o <= r_o + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_conv1d_pe_sequencer.sv
// Directed bench: clk-synchronous peer models for memories, multiplier and psum collector.
module tb_conv1d_pe_sequencer;
    import conv_pe_pkg::*;

    logic clk = 1'b0;
    logic rst, start, done;
    logic if_raddr_req, if_raddr_ack, if_rdata_req, if_rdata_ack;
    logic f_raddr_req, f_raddr_ack, f_rdata_req, f_rdata_ack;
    logic mul_a_req, mul_a_ack, mul_b_req, mul_b_ack, mul_p_req, mul_p_ack;
    logic psum_req, psum_ack;
    logic [2:0]  if_raddr_data;
    logic [1:0]  f_raddr_data;
    logic [7:0]  if_rdata_data, f_rdata_data, mul_a_data, mul_b_data;
    logic [15:0] mul_p_data;
    logic [17:0] psum_data;

    always #5 clk = ~clk;

    conv1d_pe_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .if_raddr_req(if_raddr_req), .if_raddr_ack(if_raddr_ack), .if_raddr_data(if_raddr_data),
        .if_rdata_req(if_rdata_req), .if_rdata_ack(if_rdata_ack), .if_rdata_data(if_rdata_data),
        .f_raddr_req(f_raddr_req), .f_raddr_ack(f_raddr_ack), .f_raddr_data(f_raddr_data),
        .f_rdata_req(f_rdata_req), .f_rdata_ack(f_rdata_ack), .f_rdata_data(f_rdata_data),
        .mul_a_req(mul_a_req), .mul_a_ack(mul_a_ack), .mul_a_data(mul_a_data),
        .mul_b_req(mul_b_req), .mul_b_ack(mul_b_ack), .mul_b_data(mul_b_data),
        .mul_p_req(mul_p_req), .mul_p_ack(mul_p_ack), .mul_p_data(mul_p_data),
        .psum_req(psum_req), .psum_ack(psum_ack), .psum_data(psum_data));

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int viol_if = 0, viol_f = 0, viol_m = 0, viol_p = 0;
    int if_adly, f_adly, if_ddly, f_ddly, mul_dly, ps_adly, ps_hold;
    logic [7:0] if_mem [5];
    logic [7:0] f_mem [3];
    int psum_q[$];
    int ia_log[$];
    int fa_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Receiving end of a 4-phase channel; counts protocol violations by the sender.
    task automatic rx_step(input logic req, input logic [31:0] din, input int a_dly, input int hold,
                           inout int st, inout int cnt, inout logic ack, inout logic [31:0] cap,
                           inout int viol, output logic fin);
        fin = 1'b0;
        case (st)
            0: if (req) begin cap = din; cnt = a_dly; st = 1; end
            1: if (!req || din != cap) viol++;
            2: if (!req) begin cnt = hold; st = 3; end else if (din != cap) viol++;
            default: ;
        endcase
        if (st == 1) begin
            if (cnt == 0) begin ack = 1'b1; st = 2; end else cnt--;
        end
        if (st == 3) begin
            if (cnt == 0) begin ack = 1'b0; fin = 1'b1; st = 0; end else cnt--;
        end
    endtask

    // Sending end of a 4-phase channel; the caller sets data and st=1 to start.
    task automatic tx_step(input logic ack_in, inout int st, inout int cnt, inout logic req);
        case (st)
            1: if (cnt == 0) begin req = 1'b1; st = 2; end else cnt--;
            2: if (ack_in) begin req = 1'b0; st = 3; end
            3: if (!ack_in) st = 0;
            default: ;
        endcase
    endtask

    int ia_st, ia_cnt, ir_st, ir_cnt;
    logic [31:0] ia_cap;
    logic fin_ia;
    initial begin
        if_raddr_ack = 1'b0; if_rdata_req = 1'b0; if_rdata_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ia_st = 0; ir_st = 0; if_raddr_ack = 1'b0; if_rdata_req = 1'b0;
            end else begin
                rx_step(if_raddr_req, 32'(if_raddr_data), if_adly, 0, ia_st, ia_cnt, if_raddr_ack,
                        ia_cap, viol_if, fin_ia);
                if (fin_ia) begin
                    ia_log.push_back(int'(ia_cap));
                    if_rdata_data = if_mem[ia_cap[2:0]];
                    ir_st = 1; ir_cnt = if_ddly;
                end
                tx_step(if_rdata_ack, ir_st, ir_cnt, if_rdata_req);
            end
        end
    end

    int fa_st, fa_cnt, fr_st, fr_cnt;
    logic [31:0] fa_cap;
    logic fin_fa;
    initial begin
        f_raddr_ack = 1'b0; f_rdata_req = 1'b0; f_rdata_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                fa_st = 0; fr_st = 0; f_raddr_ack = 1'b0; f_rdata_req = 1'b0;
            end else begin
                rx_step(f_raddr_req, 32'(f_raddr_data), f_adly, 0, fa_st, fa_cnt, f_raddr_ack,
                        fa_cap, viol_f, fin_fa);
                if (fin_fa) begin
                    fa_log.push_back(int'(fa_cap));
                    f_rdata_data = f_mem[fa_cap[1:0]];
                    fr_st = 1; fr_cnt = f_ddly;
                end
                tx_step(f_rdata_ack, fr_st, fr_cnt, f_rdata_req);
            end
        end
    end

    int ma_st, ma_cnt, mb_st, mb_cnt, mp_st, mp_cnt;
    logic [31:0] ma_cap, mb_cap;
    logic fin_ma, fin_mb, got_a, got_b;
    initial begin
        mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_p_req = 1'b0; mul_p_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ma_st = 0; mb_st = 0; mp_st = 0; got_a = 1'b0; got_b = 1'b0;
                mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_p_req = 1'b0;
            end else begin
                rx_step(mul_a_req, 32'(mul_a_data), 0, 0, ma_st, ma_cnt, mul_a_ack, ma_cap, viol_m, fin_ma);
                rx_step(mul_b_req, 32'(mul_b_data), 0, 0, mb_st, mb_cnt, mul_b_ack, mb_cap, viol_m, fin_mb);
                if (fin_ma) got_a = 1'b1;
                if (fin_mb) got_b = 1'b1;
                if (got_a && got_b) begin
                    got_a = 1'b0; got_b = 1'b0;
                    mul_p_data = {8'd0, ma_cap[7:0]} * {8'd0, mb_cap[7:0]};
                    mp_st = 1; mp_cnt = mul_dly;
                end
                tx_step(mul_p_ack, mp_st, mp_cnt, mul_p_req);
            end
        end
    end

    int ps_st, ps_cnt;
    logic [31:0] ps_cap;
    logic fin_ps;
    initial begin
        psum_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                ps_st = 0; psum_ack = 1'b0;
            end else begin
                rx_step(psum_req, 32'(psum_data), ps_adly, ps_hold, ps_st, ps_cnt, psum_ack, ps_cap, viol_p, fin_ps);
                if (fin_ps) psum_q.push_back(int'(ps_cap));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic run_conv(input string tag, input int e0, input int e1, input int e2,
                            input bit hold, input bit chk_addr);
        int  d0;
        bit  seen, pulsed;
        int  exp_v[3];
        int  exp_ia[9];
        exp_v  = '{e0, e1, e2};
        exp_ia = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        psum_q.delete(); ia_log.delete(); fa_log.delete();
        d0 = done_cnt; seen = 1'b0; pulsed = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            if (hold && !pulsed && mul_p_req) begin
                start = 1'b0; @(posedge clk); #1; start = 1'b1; pulsed = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (hold ? 200 : 20) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        check({tag, "_psum_cnt"}, psum_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_psum%0d", tag, i), (i < psum_q.size()) ? psum_q[i] : -1, exp_v[i]);
        check({tag, "_idle"}, 32'(dut.r_state), 32'(S_IDLE));
        if (chk_addr) begin
            check({tag, "_ia_cnt"}, ia_log.size(), 32'd9);
            check({tag, "_fa_cnt"}, fa_log.size(), 32'd9);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("%s_ia%0d", tag, i), (i < ia_log.size()) ? ia_log[i] : -1, exp_ia[i]);
                check($sformatf("%s_fa%0d", tag, i), (i < fa_log.size()) ? fa_log[i] : -1, i % 3);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        if_adly = 0; f_adly = 0; if_ddly = 4; f_ddly = 4; mul_dly = 4; ps_adly = 0; ps_hold = 0;
        if_mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        f_mem  = '{8'd1, 8'd1, 8'd1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_hs", {if_raddr_req, f_raddr_req, if_rdata_ack, f_rdata_ack, mul_a_req, mul_b_req,
                         mul_p_ack, psum_req, done}, 32'd0);
        rst = 1'b0;

        // Reset while mid-RADDR
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !if_raddr_req; c++) begin @(posedge clk); #1; end
        check("t1_in_raddr", 32'(if_raddr_req), 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t1_hs", {if_raddr_req, f_raddr_req, if_rdata_ack, f_rdata_ack, mul_a_req, mul_b_req,
                        mul_p_ack, psum_req, done}, 32'd0);
        check("t1_state", 32'(dut.r_state), 32'(S_IDLE));
        check("t1_psum", 32'(dut.r_psum), 32'd0);
        check("t1_data", {if_raddr_data, f_raddr_data, psum_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_conv("t2", 6, 9, 12, 1'b0, 1'b1);

        if_mem = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        f_mem  = '{8'd255, 8'd255, 8'd255};
        run_conv("t4", 195075, 195075, 195075, 1'b0, 1'b0);

        if_mem = '{8'd5, 8'd0, 8'd7, 8'd2, 8'd9};
        f_mem  = '{8'd2, 8'd3, 8'd1};
        run_conv("tmix", 17, 23, 29, 1'b0, 1'b1);

        if_mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        f_mem  = '{8'd1, 8'd1, 8'd1};
        f_adly = 10; if_ddly = 28; ps_adly = 3; ps_hold = 20;
        run_conv("t5", 6, 9, 12, 1'b0, 1'b1);

        f_adly = 0; if_ddly = 4; ps_adly = 0; ps_hold = 0;
        run_conv("t6", 6, 9, 12, 1'b1, 1'b0);

        check("proto_viol", viol_if + viol_f + viol_m + viol_p, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
